packet_sorter_rdy: RTL and testbench

- Second-generation packet sorter.
- Accepts one packet of up to 2**AWIDTH words on a sop/eop/val stream. Sorts it in a register array with an odd-even transposition network, then streams it out on the same sop/eop/val framing.
- Adds over the first generation:
  - per-packet sort direction;
  - output back-pressure (ready_i);
  - fixed, length-independent sort latency;
  - overflow/framing error reporting.
- Sits between the packet source and the downstream consumer; busy_o throttles the source.

---
 rtl/packet_sorter_pkg.sv | 27 ++
 rtl/packet_sorter_rdy_cmp_swap.sv | 25 ++
 rtl/packet_sorter_rdy.sv | 190 +++++++++++++++++++
 tb/tb_packet_sorter_rdy.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_sorter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : packet_sorter_pkg
// Brief    : Shared FSM encoding and sizing helpers for the packet sorter.
// Revision : 1.0 - initial release
// ============================================================================
package packet_sorter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic int depth_of(input int awidth);
        return 1 << awidth;
    endfunction

    // Length must represent 1..DEPTH inclusive, hence one extra bit.
    function automatic int len_width(input int awidth);
        return awidth + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_sorter_rdy_cmp_swap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cmp_swap
// Brief    : Combinational compare-exchange of two unsigned words.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_swap #(
    parameter int DWIDTH = 8
) (
    input  logic [DWIDTH-1:0] a_i,
    input  logic [DWIDTH-1:0] b_i,
    input  logic              desc_i,
    output logic [DWIDTH-1:0] first_o,
    output logic [DWIDTH-1:0] second_o
);

    logic w_swap;

    assign w_swap   = desc_i ? (a_i < b_i) : (a_i > b_i);
    assign first_o  = w_swap ? b_i : a_i;
    assign second_o = w_swap ? a_i : b_i;

endmodule
`default_nettype wire

// File: rtl/packet_sorter_rdy.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : packet_sorter_rdy
// Brief    : Buffers one sop/eop packet, sorts it with an odd-even
//            transposition network in DEPTH cycles, streams it out with ready.
// Revision : 1.0 - initial release
// ============================================================================
module packet_sorter_rdy
    import packet_sorter_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    input  logic              desc_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int DEPTH = depth_of(AWIDTH);
    localparam int LW    = len_width(AWIDTH);

    state_t             r_state;
    logic [LW-1:0]      r_len;
    logic [AWIDTH-1:0]  r_cnt;
    logic [AWIDTH-1:0]  r_rd;
    logic               r_desc;
    logic               r_ovf;
    logic               r_val;
    logic               r_err;
    logic [DWIDTH-1:0]  r_mem [DEPTH];

    logic [DWIDTH-1:0]  w_in     [DEPTH];
    logic [DWIDTH-1:0]  w_next   [DEPTH];
    logic [DWIDTH-1:0]  w_first  [DEPTH-1];
    logic [DWIDTH-1:0]  w_second [DEPTH-1];
    logic [DWIDTH-1:0]  w_pad;
    logic               w_beat;
    logic               w_phase;
    logic               w_full;
    logic               w_last_rd;
    logic               w_wr_en;
    logic [AWIDTH-1:0]  w_wr_idx;

    assign w_beat    = val_i && !busy_o;
    assign w_phase   = r_cnt[0];
    assign w_full    = (r_len == LW'(DEPTH));
    assign w_last_rd = ({1'b0, r_rd} == (r_len - LW'(1)));
    // Pad sorts to the tail: maximum for ascending, minimum for descending.
    assign w_pad     = {DWIDTH{~r_desc}};

    generate
        for (genvar j = 0; j < DEPTH; j++) begin : g_in
            assign w_in[j] = (LW'(j) < r_len) ? r_mem[j] : w_pad;
        end

        for (genvar i = 0; i < DEPTH - 1; i++) begin : g_pair
            cmp_swap #(
                .DWIDTH (DWIDTH)
            ) u_cmp_swap (
                .a_i      (w_in[i]),
                .b_i      (w_in[i+1]),
                .desc_i   (r_desc),
                .first_o  (w_first[i]),
                .second_o (w_second[i])
            );
        end

        // Pair p is active when its index parity matches the sort phase.
        for (genvar j = 0; j < DEPTH; j++) begin : g_pos
            if (j == 0) begin : g_head
                assign w_next[j] = (w_phase == 1'b0) ? w_first[0] : w_in[0];
            end else if (j == DEPTH - 1) begin : g_tail
                assign w_next[j] = (w_phase == 1'((j - 1) % 2)) ? w_second[j-1] : w_in[j];
            end else begin : g_mid
                assign w_next[j] = (w_phase == 1'(j % 2)) ? w_first[j] : w_second[j-1];
            end
        end
    endgenerate

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        if (w_beat) begin
            if ((r_state == IDLE || r_state == LOAD) && sop_i) begin
                w_wr_en = 1'b1;
            end else if (r_state == LOAD && !w_full) begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_len[AWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_state == SORT) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= w_next[j];
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_desc  <= 1'b0;
            r_ovf   <= 1'b0;
            r_val   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_beat && sop_i) begin
                        r_len   <= LW'(1);
                        r_desc  <= desc_i;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= eop_i ? SORT : LOAD;
                    end
                end
                LOAD: begin
                    if (w_beat) begin
                        if (sop_i) begin
                            r_len   <= LW'(1);
                            r_desc  <= desc_i;
                            r_ovf   <= 1'b0;
                            r_err   <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= eop_i ? SORT : LOAD;
                        end else begin
                            if (!w_full) begin
                                r_len <= r_len + LW'(1);
                            end
                            r_ovf <= r_ovf | w_full;
                            if (eop_i) begin
                                r_err   <= r_ovf | w_full;
                                r_cnt   <= '0;
                                r_state <= SORT;
                            end
                        end
                    end
                end
                SORT: begin
                    r_cnt <= r_cnt + AWIDTH'(1);
                    if (r_cnt == AWIDTH'(DEPTH - 1)) begin
                        r_state <= OUT;
                        r_val   <= 1'b1;
                        r_rd    <= '0;
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        if (w_last_rd) begin
                            r_state <= IDLE;
                            r_val   <= 1'b0;
                        end else begin
                            r_rd <= r_rd + AWIDTH'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o = (r_state == SORT) || (r_state == OUT);
    assign val_o  = r_val;
    assign data_o = r_val ? r_mem[r_rd] : '0;
    assign sop_o  = r_val && (r_rd == '0);
    assign eop_o  = r_val && w_last_rd;
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_packet_sorter_rdy.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_packet_sorter_rdy
// Brief    : Directed vector bench for packet_sorter_rdy (DEPTH=8, DWIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_sorter_rdy;

    logic       clk = 1'b0;
    logic       srst_i;
    logic [7:0] data_i;
    logic       sop_i, eop_i, val_i, desc_i, ready_i;
    logic [7:0] data_o;
    logic       sop_o, eop_o, val_o, busy_o, err_o;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    packet_sorter_rdy #(.AWIDTH(3), .DWIDTH(8)) dut (
        .clk_i   (clk),
        .srst_i  (srst_i),
        .data_i  (data_i),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .val_i   (val_i),
        .desc_i  (desc_i),
        .data_o  (data_o),
        .sop_o   (sop_o),
        .eop_o   (eop_o),
        .val_o   (val_o),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    typedef struct {
        int         n;
        logic       desc;
        logic [7:0] din  [12];
        int         nexp;
        logic [7:0] dexp [8];
        logic       exp_err;
        int         rmode;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        val_i  = 1'b0;
        sop_i  = 1'b0;
        eop_i  = 1'b0;
        data_i = 8'h00;
        desc_i = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic s, input logic e,
                             input logic dsc, output logic err_seen);
        val_i  = 1'b1;
        data_i = d;
        sop_i  = s;
        eop_i  = e;
        desc_i = dsc;
        @(posedge clk);
        #1;
        err_seen = err_o;
    endtask

    task automatic send_list(input logic [7:0] d [12], input int n, input logic dsc,
                             output logic early_err, output logic last_err, output int eop_cyc);
        logic e;
        early_err = 1'b0;
        last_err  = 1'b0;
        eop_cyc   = 0;
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) eop_cyc = cyc;
            send_beat(d[k], k == 0, k == n - 1, dsc, e);
            if (k < n - 1) early_err |= e;
            else           last_err = e;
        end
        idle_inputs();
    endtask

    // rmode 0: ready held high; rmode 1: ready pattern 1,0,0 repeating.
    task automatic collect(input string tag, input int nexp, input logic [7:0] dexp [8],
                           input int rmode, output int sop_cyc);
        int         idx   = 0;
        int         k     = 0;
        int         guard = 0;
        logic       held  = 1'b0;
        logic [7:0] hd;
        logic       hs, he;
        sop_cyc = -1;
        while (idx < nexp && guard < 200) begin
            ready_i = (rmode == 0) ? 1'b1 : ((k % 3) == 0);
            k++;
            if (rmode == 0 && idx > 0) chk({tag, " contiguous val_o"}, val_o, 1);
            if (val_o) begin
                if (held) begin
                    chk({tag, " stall data"}, data_o, hd);
                    chk({tag, " stall sop"},  sop_o,  hs);
                    chk({tag, " stall eop"},  eop_o,  he);
                end
                if (ready_i) begin
                    chk({tag, " data"}, data_o, dexp[idx]);
                    chk({tag, " sop"},  sop_o,  idx == 0);
                    chk({tag, " eop"},  eop_o,  idx == nexp - 1);
                    if (idx == 0) sop_cyc = cyc;
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = data_o;
                    hs   = sop_o;
                    he   = eop_o;
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        ready_i = 1'b1;
        chk({tag, " beat count"}, idx, nexp);
        chk({tag, " val_o after eop"}, val_o, 0);
        chk({tag, " busy_o after eop"}, busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ee, le, e;
        int         eop_cyc, sop_cyc, seen;
        logic [7:0] pk [12];
        logic [7:0] ex [8];

        vt[0].n = 4;  vt[0].desc = 1'b0; vt[0].nexp = 4; vt[0].exp_err = 1'b0; vt[0].rmode = 0;
        vt[0].din  = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[0].dexp = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[1].n = 8;  vt[1].desc = 1'b1; vt[1].nexp = 8; vt[1].exp_err = 1'b0; vt[1].rmode = 0;
        vt[1].din  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[1].dexp = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        vt[2].n = 1;  vt[2].desc = 1'b0; vt[2].nexp = 1; vt[2].exp_err = 1'b0; vt[2].rmode = 0;
        vt[2].din  = '{8'hAA, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[2].dexp = '{8'hAA, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[3] = vt[0];
        vt[3].rmode = 1;
        vt[4].n = 10; vt[4].desc = 1'b0; vt[4].nexp = 8; vt[4].exp_err = 1'b1; vt[4].rmode = 0;
        vt[4].din  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        vt[4].dexp = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        vt[5].n = 3;  vt[5].desc = 1'b0; vt[5].nexp = 3; vt[5].exp_err = 1'b0; vt[5].rmode = 0;
        vt[5].din  = '{8'hFF, 8'h00, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[5].dexp = '{8'h00, 8'hFF, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[6].n = 5;  vt[6].desc = 1'b1; vt[6].nexp = 5; vt[6].exp_err = 1'b0; vt[6].rmode = 0;
        vt[6].din  = '{8'd4, 8'd1, 8'd4, 8'd0, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vt[6].dexp = '{8'd9, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};

        idle_inputs();
        ready_i = 1'b1;
        srst_i  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset val_o",  val_o,  0);
        chk("reset sop_o",  sop_o,  0);
        chk("reset eop_o",  eop_o,  0);
        chk("reset busy_o", busy_o, 0);
        chk("reset err_o",  err_o,  0);
        chk("reset data_o", data_o, 0);
        srst_i = 1'b0;

        for (int v = 0; v < 7; v++) begin
            send_list(vt[v].din, vt[v].n, vt[v].desc, ee, le, eop_cyc);
            chk($sformatf("vec%0d err during load", v), ee, 0);
            chk($sformatf("vec%0d err after eop", v), le, vt[v].exp_err);
            chk($sformatf("vec%0d busy after eop", v), busy_o, 1);
            collect($sformatf("vec%0d", v), vt[v].nexp, vt[v].dexp, vt[v].rmode, sop_cyc);
            if (v == 0) chk("vec0 sop latency", sop_cyc - eop_cyc, 9);
        end

        // Beat without sop in IDLE is dropped silently.
        send_beat(8'h11, 1'b0, 1'b1, 1'b0, e);
        idle_inputs();
        seen = 0;
        repeat (12) begin
            if (val_o || busy_o || err_o) seen++;
            @(posedge clk);
            #1;
        end
        chk("idle drop err", e, 0);
        chk("idle drop no activity", seen, 0);

        // sop in the middle of LOAD restarts the packet.
        send_beat(8'd5, 1'b1, 1'b0, 1'b0, e);
        chk("restart first beat err", e, 0);
        send_beat(8'd6, 1'b0, 1'b0, 1'b0, e);
        send_beat(8'd2, 1'b1, 1'b0, 1'b0, e);
        chk("restart err pulse", e, 1);
        send_beat(8'd9, 1'b0, 1'b0, 1'b0, e);
        chk("restart err one cycle", e, 0);
        send_beat(8'd1, 1'b0, 1'b1, 1'b0, e);
        chk("restart eop err", e, 0);
        idle_inputs();
        ex = '{8'd1, 8'd2, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        collect("restart", 3, ex, 0, sop_cyc);

        // Beats offered while busy are ignored.
        pk = '{8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_list(pk, 2, 1'b0, ee, le, eop_cyc);
        repeat (4) begin
            send_beat(8'h55, 1'b1, 1'b1, 1'b1, e);
        end
        idle_inputs();
        ex = '{8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        collect("busy ignore", 2, ex, 0, sop_cyc);
        seen = 0;
        repeat (12) begin
            if (val_o || busy_o) seen++;
            @(posedge clk);
            #1;
        end
        chk("busy ignore no stray packet", seen, 0);

        // Reset while streaming out aborts the packet.
        pk = '{8'd4, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_list(pk, 2, 1'b0, ee, le, eop_cyc);
        for (int g = 0; g < 30 && !val_o; g++) begin
            @(posedge clk);
            #1;
        end
        chk("reset-in-out reached OUT", val_o, 1);
        srst_i = 1'b1;
        @(posedge clk);
        #1;
        srst_i = 1'b0;
        chk("reset-in-out val_o",  val_o,  0);
        chk("reset-in-out busy_o", busy_o, 0);
        chk("reset-in-out sop_o",  sop_o,  0);
        chk("reset-in-out err_o",  err_o,  0);
        pk = '{8'd8, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_list(pk, 3, 1'b1, ee, le, eop_cyc);
        chk("post-reset err", le, 0);
        ex = '{8'd8, 8'd7, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        collect("post-reset", 3, ex, 0, sop_cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
